// File: rtl/led_seq_ctrl.sv
// Board status LED sequencer: debounced mode key, host cfg port, blink prescaler
// and the four display modes (rotate left/right, blink, hold).
module led_seq_ctrl #(
  parameter int TICK_DIV        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LED_W           = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_mode,
  output logic             cfg_ready,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [DB_W-1:0]  DB_ZERO   = DB_W'(0);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LED_W-1:0] LED_LSB   = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_ALL   = {LED_W{1'b1}};

  localparam logic [1:0] MODE_ROT_L = 2'd0;
  localparam logic [1:0] MODE_ROT_R = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } state_t;

  logic [1:0]       key_sync_r;
  logic             key_db_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic             press_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [LED_W-1:0] led_r;
  logic [1:0]       mode_r;
  logic             tick_r;
  logic             ready_r;
  logic             key_pend_r;

  logic [LED_W-1:0] step_s;
  logic [LED_W-1:0] init_s;
  logic             cfg_fire_s;
  logic             key_req_s;

  assign cfg_ready = ready_r;
  assign led       = led_r;
  assign mode      = mode_r;
  assign tick      = tick_r;

  // Synchronize and debounce the key; press_r pulses for one cycle on a debounced fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sync_r <= 2'b11;
      key_db_r   <= 1'b1;
      db_cnt_r   <= DB_ZERO;
      press_r    <= 1'b0;
    end else begin
      key_sync_r <= {key_sync_r[0], key_n};
      press_r    <= 1'b0;
      if (key_sync_r[1] == key_db_r) begin
        db_cnt_r <= DB_ZERO;
      end else if (db_cnt_r == DB_LAST) begin
        key_db_r <= key_sync_r[1];
        db_cnt_r <= DB_ZERO;
        press_r  <= ~key_sync_r[1];
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end
    end
  end

  // Next pattern for a step and the pattern loaded on entering the current mode.
  always_comb begin
    step_s = led_r;
    init_s = led_r;
    case (mode_r)
      MODE_ROT_L: begin
        step_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
        init_s = LED_LSB;
      end
      MODE_ROT_R: begin
        step_s = {led_r[0], led_r[LED_W-1:1]};
        init_s = LED_LSB;
      end
      MODE_BLINK: begin
        step_s = ~led_r;
        init_s = LED_ALL;
      end
      MODE_HOLD: begin
        step_s = led_r;
        init_s = led_r;
      end
      default: begin
        step_s = led_r;
        init_s = led_r;
      end
    endcase
  end

  assign cfg_fire_s = cfg_valid & ready_r;
  assign key_req_s  = press_r | key_pend_r;

  // Mode FSM: RUN steps the pattern on prescaler wrap; SWITCH reloads it for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      cnt_r      <= CNT_ZERO;
      led_r      <= LED_LSB;
      mode_r     <= MODE_ROT_L;
      tick_r     <= 1'b0;
      ready_r    <= 1'b1;
      key_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (cfg_fire_s || key_req_s) begin
            // cfg has priority; a simultaneous key request is dropped
            mode_r     <= cfg_fire_s ? cfg_mode : (mode_r + 2'd1);
            key_pend_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
            tick_r     <= 1'b0;
            ready_r    <= 1'b0;
            state_r    <= ST_SWITCH;
          end else begin
            if (cnt_r == TICK_LAST) begin
              led_r <= step_s;
              cnt_r <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
            tick_r <= (cnt_r == TICK_PRE);
          end
        end
        ST_SWITCH: begin
          led_r   <= init_s;
          cnt_r   <= CNT_ZERO;
          tick_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_RUN;
          if (press_r) begin
            key_pend_r <= 1'b1;
          end else begin
            key_pend_r <= key_pend_r;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          tick_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: a behavioural model queues the expected
// outputs each clock edge, and a monitor compares them half a cycle later.
module tb_led_seq_ctrl;

  localparam int T = 4;
  localparam int D = 8;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] led;
    logic [1:0]   mode;
    logic         tick;
    logic         ready;
  } obs_t;

  logic         clk;
  logic         rst;
  logic         key_n;
  logic         cfg_valid;
  logic [1:0]   cfg_mode;
  logic         cfg_ready;
  logic [W-1:0] led;
  logic [1:0]   mode;
  logic         tick;

  int n_tests = 0;
  int n_fail  = 0;
  obs_t sb[$];

  led_seq_ctrl #(.TICK_DIV(T), .DEBOUNCE_CYCLES(D), .LED_W(W)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .cfg_valid(cfg_valid),
    .cfg_mode(cfg_mode), .cfg_ready(cfg_ready), .led(led), .mode(mode), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: pattern, mode, steps since (re)start, switching flag.
  int m_led, m_mode, m_phase;
  bit m_sw, m_pend, m_press, m_db;
  bit kq[$];

  function automatic int step_f(int l, int md);
    int mask;
    mask = (1 << W) - 1;
    case (md)
      0: return ((l << 1) | (l >> (W - 1))) & mask;
      1: return ((l >> 1) | ((l & 1) << (W - 1))) & mask;
      2: return (~l) & mask;
      default: return l;
    endcase
  endfunction

  function automatic int init_f(int l, int md);
    if (md <= 1) return 1;
    if (md == 2) return (1 << W) - 1;
    return l;
  endfunction

  task automatic model_edge();
    obs_t e;
    bit press_now, differ;
    if (rst) begin
      m_led = 1; m_mode = 0; m_phase = 0;
      m_sw = 1'b0; m_pend = 1'b0; m_press = 1'b0; m_db = 1'b1;
      kq.delete();
      kq.push_back(1'b1);
      kq.push_back(1'b1);
    end else begin
      press_now = m_press;
      m_press = 1'b0;
      // debounced level flips once the synchronized key has differed for D edges
      if (kq.size() >= D + 1) begin
        differ = 1'b1;
        for (int j = 1; j <= D; j++)
          if (kq[kq.size() - 1 - j] == m_db) differ = 1'b0;
        if (differ) begin
          m_db = ~m_db;
          m_press = !m_db;
        end
      end
      kq.push_back(key_n);
      while (kq.size() > D + 2) void'(kq.pop_front());
      if (!m_sw) begin
        if (cfg_valid) begin
          m_mode = cfg_mode; m_pend = 1'b0; m_sw = 1'b1; m_phase = 0;
        end else if (press_now || m_pend) begin
          m_mode = (m_mode + 1) % 4; m_pend = 1'b0; m_sw = 1'b1; m_phase = 0;
        end else begin
          if (m_phase == T - 1) m_led = step_f(m_led, m_mode);
          m_phase = (m_phase + 1) % T;
        end
      end else begin
        if (press_now) m_pend = 1'b1;
        m_led = init_f(m_led, m_mode);
        m_sw = 1'b0;
        m_phase = 0;
      end
    end
    e.led   = W'(m_led);
    e.mode  = 2'(m_mode);
    e.tick  = !m_sw && (m_phase == T - 1);
    e.ready = !m_sw;
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {led, mode, tick, cfg_ready};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL out_check t=%0t got led=%b mode=%0d tick=%b rdy=%b, want led=%b mode=%0d tick=%b rdy=%b",
                   $time, a.led, a.mode, a.tick, a.ready, e.led, e.mode, e.tick, e.ready);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_pulse(logic [1:0] md);
    cfg_valid = 1'b1;
    cfg_mode  = md;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int hold;
    rst = 1'b1; key_n = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0;
    cyc(2);
    rst = 1'b0;
    cyc(16);                           // four rotate-left steps
    cyc(3);                            // prescaler now at its last count
    cfg_pulse(2'd2);
    cyc(8);
    for (int i = 0; i < 10; i++) begin // bouncing key
      key_n = ~key_n;
      cyc(3);
    end
    key_n = 1'b0; cyc(14); key_n = 1'b1; cyc(14);
    repeat (4) begin
      key_n = 1'b0; cyc(14); key_n = 1'b1; cyc(14);
    end
    key_n = 1'b0; cyc(10);             // press coincident with cfg mode 3
    cfg_pulse(2'd3);
    key_n = 1'b1; cyc(14);
    key_n = 1'b0; cyc(9);              // press landing in SWITCH
    cfg_pulse(2'd1);
    key_n = 1'b1; cyc(20);
    cfg_pulse(2'd0);                   // walk to 0100, then hold
    cyc(9);
    cfg_pulse(2'd3);
    cyc(22);
    cfg_pulse(2'd1);
    cyc(8);
    cfg_pulse(2'd2);                   // reset during SWITCH
    rst = 1'b1; cyc(1); rst = 1'b0;
    cyc(8);
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 40 == 0) begin
        cfg_valid = 1'b1;
        cfg_mode  = 2'($urandom);
      end else begin
        cfg_valid = 1'b0;
      end
      if (hold == 0) begin
        key_n = 1'($urandom);
        hold  = $urandom_range(1, 20);
      end else begin
        hold--;
      end
      rst = ($urandom % 400 == 0);
      cyc(1);
    end
    rst = 1'b0; cfg_valid = 1'b0;
    cyc(3);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
